priority_arbiter_ctrl: RTL and testbench
========================================

// Module: priority_arbiter_ctrl
// PURPOSE
//  Arbitrates one shared resource among N requesters, using the priority-encoder ordering (highest index wins).
//  Registers a one-hot grant plus its binary index, and holds the grant until the owner drops its request.
//  A hold-time limit forces release, so one requester cannot starve the others.
//  Sits in front of the shared mux/decoder datapath; gnt_id drives that mux select directly.
// PARAMETERS
//  N         8   number of requesters
//  IDW       3   width of gnt_id, clog2(N)
//  MAX_HOLD  16  max cycles a grant is held before forced release; 0 = no limit
//  CNT_W     8   hold-counter width; must satisfy MAX_HOLD < 2**CNT_W
// PORTS
//  clk        in   1    single clock; all logic on posedge
//  rst_n      in   1    reset, synchronous, active-low
//  en         in   1    arbitration enable; gates new grants only
//  req        in   N    request vector, level-sensitive, one bit per requester
//  gnt        out  N    one-hot grant, registered
//  gnt_id     out  IDW  binary index of granted requester, registered
//  gnt_valid  out  1    high while any grant is held; equals |gnt
//  timeout    out  1    one-cycle pulse when a grant is forcibly revoked
// BEHAVIOUR
//  Reset (rst_n low at posedge): state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold_cnt=0,
//    mask=0, rr_ptr=N-1. Reset overrides everything, including mid-grant; gnt drops at that edge.
//  FSM, two states: IDLE and GRANT.
//  IDLE: when en=1 and |(req & ~mask)!=0, the winner is latched at the posedge.
//    From that edge: gnt=onehot(w), gnt_id=w, gnt_valid=1, hold_cnt=0, go to GRANT.
//    Latency: req sampled at edge k -> gnt visible after edge k.
//    The arbitration clears mask (mask applies to exactly one arbitration).
//    When en=0 or there is no eligible request: stay in IDLE with outputs 0.
//  GRANT: en is ignored; an active grant is never preempted by en or by higher-priority requests.
//    req[gnt_id]=0 -> release: next edge gnt=0, gnt_valid=0, go to IDLE (mandatory 1-cycle bubble).
//    Else, if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 -> forced release: next edge gnt=0, timeout=1 for
//      one cycle, mask=onehot(gnt_id), go to IDLE.
//    Else: hold_cnt increments.
//    A grant is therefore held at most MAX_HOLD cycles.
//  Release and timeout in the same cycle: the release wins and no timeout pulse is issued.
//  Masked requester is the only requester: mask blocks it for one IDLE cycle, then it is re-granted.
//  Requests that change while in GRANT have no effect until the next IDLE arbitration.
//  gnt is always one-hot or zero; gnt_id holds its last value while gnt_valid=0.
// CONFIGURATION
//  ROUND_ROBIN_EN defined:
//    - Rotating priority. Search order is rr_ptr, rr_ptr-1, ..., 0, N-1, ... (wraps around).
//    - On each grant of w: rr_ptr <= (w==0) ? N-1 : w-1, so w becomes lowest priority.
//  ROUND_ROBIN_EN undefined:
//    - Fixed priority: req[N-1] highest, req[0] lowest.
//    - rr_ptr logic is absent; fairness comes only from the timeout mask.
// TESTING
//  1 rst_n=0, req=8'hFF, en=1 for 3 cycles -> gnt=0, gnt_valid=0, timeout=0 throughout.
//  2 en=0, req=8'h05 -> no grant. Raise en=1 -> one edge later gnt=8'h04, gnt_id=2.
//  3 Holder 7, req goes 8'hC1 -> 8'h41 -> 1 cycle gnt=0, then gnt=8'h40, gnt_id=6.
//  4 MAX_HOLD=4, req=8'h81 held -> id7 for 4 cycles, timeout pulse, bubble, then id0 granted.
//    Repeat with req=8'h80 -> id7, timeout, 2 IDLE cycles (bubble + mask), then id7 again.
//  5 MAX_HOLD=2, req=8'hFF held -> fixed priority grants ids 7,6,7,6...
//    With ROUND_ROBIN_EN the sequence is 7,6,5,4,3,2,1,0,7.
//  6 Reset asserted mid-grant (holder 5) -> gnt=0 at that edge; after reset, req=8'h21 -> id5 (RR ptr restored).

Source files
------------

// File: rtl/priority_arbiter_ctrl.sv
// Grant/hold arbiter for one shared resource, with a hold-time limit that forces release.
// Define ROUND_ROBIN_EN for rotating priority; the default build uses fixed priority (highest index wins).
module priority_arbiter_ctrl #(
  parameter int N        = 8,
  parameter int IDW      = 3,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [N-1:0]     ONE_HOT0     = {{(N-1){1'b0}}, 1'b1};
  localparam bit               HOLD_LIMITED = (MAX_HOLD > 0);
  localparam logic [CNT_W-1:0] HOLD_LAST    = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

  state_t           state, state_nxt;
  logic [N-1:0]     mask, mask_nxt;
  logic [N-1:0]     gnt_nxt;
  logic [N-1:0]     eligible;
  logic [IDW-1:0]   gnt_id_nxt;
  logic [IDW-1:0]   winner;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             timeout_nxt;
  logic             hold_expired;

  assign eligible     = req & ~mask;
  assign hold_expired = HOLD_LIMITED && (hold_cnt == HOLD_LAST);
  assign gnt_valid    = |gnt;

`ifdef ROUND_ROBIN_EN
  logic [IDW-1:0] rr_ptr, rr_ptr_nxt;

  // Walk downward from rr_ptr with wrap; the lowest search step that is eligible wins.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) - i;
      if (idx < 0) idx = idx + N;
      if (eligible[IDW'(idx)]) winner = IDW'(idx);
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i]) winner = IDW'(i);
    end
  end
`endif

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    gnt_id_nxt   = gnt_id;
    hold_cnt_nxt = hold_cnt;
    mask_nxt     = mask;
    timeout_nxt  = 1'b0;
`ifdef ROUND_ROBIN_EN
    rr_ptr_nxt   = rr_ptr;
`endif
    case (state)
      IDLE: begin
        // The timeout mask only ever covers a single IDLE cycle.
        mask_nxt     = '0;
        hold_cnt_nxt = '0;
        if (en && (|eligible)) begin
          state_nxt  = GRANT;
          gnt_nxt    = ONE_HOT0 << winner;
          gnt_id_nxt = winner;
`ifdef ROUND_ROBIN_EN
          rr_ptr_nxt = (winner == '0) ? IDW'(N - 1) : winner - 1'b1;
`endif
        end
      end
      GRANT: begin
        if (!req[gnt_id]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end else if (hold_expired) begin
          state_nxt   = IDLE;
          gnt_nxt     = '0;
          timeout_nxt = 1'b1;
          mask_nxt    = ONE_HOT0 << gnt_id;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      mask     <= '0;
`ifdef ROUND_ROBIN_EN
      rr_ptr   <= IDW'(N - 1);
`endif
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= gnt_id_nxt;
      timeout  <= timeout_nxt;
      hold_cnt <= hold_cnt_nxt;
      mask     <= mask_nxt;
`ifdef ROUND_ROBIN_EN
      rr_ptr   <= rr_ptr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_priority_arbiter_ctrl.sv
// Table-driven scoreboard bench for priority_arbiter_ctrl, built with MAX_HOLD=4.
module tb_priority_arbiter_ctrl;

  localparam int N        = 8;
  localparam int IDW      = 3;
  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic           timeout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       tmo;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  priority_arbiter_ctrl #(
    .N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input string name, input logic r, input logic e, input logic [7:0] rq,
                        input logic [7:0] g, input logic [2:0] id, input logic tmo);
    vec_t v;
    v.name  = name;
    v.rst_n = r;
    v.en    = e;
    v.req   = rq;
    v.gnt   = g;
    v.id    = id;
    v.valid = (g != 8'h00);
    v.tmo   = tmo;
    vecs.push_back(v);
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n = v.rst_n;
    en    = v.en;
    req   = v.req;
    exp_q.push_back(v);
  endtask

  task automatic checkOutput(input int step);
    vec_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checkValue($sformatf("scoreboard_empty[%0d]", step), 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      checkValue($sformatf("%s[%0d].gnt", e.name, step), 32'(gnt), 32'(e.gnt));
      checkValue($sformatf("%s[%0d].gnt_id", e.name, step), 32'(gnt_id), 32'(e.id));
      checkValue($sformatf("%s[%0d].gnt_valid", e.name, step), 32'(gnt_valid), 32'(e.valid));
      checkValue($sformatf("%s[%0d].timeout", e.name, step), 32'(timeout), 32'(e.tmo));
    end
  endtask

  initial begin
    int held;
    int zeros;
    logic seen;
    logic got;

    // Each row is one clock: inputs before the edge, expected registered outputs after it.
    for (int i = 0; i < 3; i++) addVec("reset", 1'b0, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0);
    addVec("en_low",   1'b1, 1'b0, 8'h05, 8'h00, 3'd0, 1'b0);
    addVec("en_low",   1'b1, 1'b0, 8'h05, 8'h00, 3'd0, 1'b0);
    addVec("en_rise",  1'b1, 1'b1, 8'h05, 8'h04, 3'd2, 1'b0);
    addVec("en_ign",   1'b1, 1'b0, 8'h05, 8'h04, 3'd2, 1'b0);
    addVec("drop2",    1'b1, 1'b1, 8'h00, 8'h00, 3'd2, 1'b0);
    addVec("grant7",   1'b1, 1'b1, 8'h80, 8'h80, 3'd7, 1'b0);
    addVec("no_pre",   1'b1, 1'b1, 8'hC1, 8'h80, 3'd7, 1'b0);
    addVec("bubble",   1'b1, 1'b1, 8'h41, 8'h00, 3'd7, 1'b0);
    addVec("grant6",   1'b1, 1'b1, 8'h41, 8'h40, 3'd6, 1'b0);
    addVec("drop6",    1'b1, 1'b1, 8'h00, 8'h00, 3'd6, 1'b0);
    addVec("reset",    1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0);
    addVec("to_g7",    1'b1, 1'b1, 8'h81, 8'h80, 3'd7, 1'b0);
    for (int i = 0; i < 3; i++) addVec("to_hold", 1'b1, 1'b1, 8'h81, 8'h80, 3'd7, 1'b0);
    addVec("to_pulse", 1'b1, 1'b1, 8'h81, 8'h00, 3'd7, 1'b1);
    addVec("to_g0",    1'b1, 1'b1, 8'h81, 8'h01, 3'd0, 1'b0);
    addVec("drop0",    1'b1, 1'b1, 8'h80, 8'h00, 3'd0, 1'b0);
    addVec("solo_g7",  1'b1, 1'b1, 8'h80, 8'h80, 3'd7, 1'b0);
    for (int i = 0; i < 3; i++) addVec("solo_hold", 1'b1, 1'b1, 8'h80, 8'h80, 3'd7, 1'b0);
    addVec("solo_to",  1'b1, 1'b1, 8'h80, 8'h00, 3'd7, 1'b1);
    addVec("solo_msk", 1'b1, 1'b1, 8'h80, 8'h00, 3'd7, 1'b0);
    addVec("solo_re",  1'b1, 1'b1, 8'h80, 8'h80, 3'd7, 1'b0);
    addVec("solo_drp", 1'b1, 1'b1, 8'h00, 8'h00, 3'd7, 1'b0);
    addVec("tie_g7",   1'b1, 1'b1, 8'h80, 8'h80, 3'd7, 1'b0);
    for (int i = 0; i < 3; i++) addVec("tie_hold", 1'b1, 1'b1, 8'h80, 8'h80, 3'd7, 1'b0);
    addVec("tie_rel",  1'b1, 1'b1, 8'h00, 8'h00, 3'd7, 1'b0);
    addVec("reset",    1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    addVec("all_g7",   1'b1, 1'b1, 8'hFF, 8'h80, 3'd7, 1'b0);
    for (int i = 0; i < 3; i++) addVec("all_hold7", 1'b1, 1'b1, 8'hFF, 8'h80, 3'd7, 1'b0);
    addVec("all_to7",  1'b1, 1'b1, 8'hFF, 8'h00, 3'd7, 1'b1);
    addVec("all_g6",   1'b1, 1'b1, 8'hFF, 8'h40, 3'd6, 1'b0);
    for (int i = 0; i < 3; i++) addVec("all_hold6", 1'b1, 1'b1, 8'hFF, 8'h40, 3'd6, 1'b0);
    addVec("all_to6",  1'b1, 1'b1, 8'hFF, 8'h00, 3'd6, 1'b1);
`ifdef ROUND_ROBIN_EN
    addVec("all_g3rd", 1'b1, 1'b1, 8'hFF, 8'h20, 3'd5, 1'b0);
    addVec("all_drop", 1'b1, 1'b1, 8'h00, 8'h00, 3'd5, 1'b0);
`else
    addVec("all_g3rd", 1'b1, 1'b1, 8'hFF, 8'h80, 3'd7, 1'b0);
    addVec("all_drop", 1'b1, 1'b1, 8'h00, 8'h00, 3'd7, 1'b0);
`endif
    addVec("mid_g5",   1'b1, 1'b1, 8'h20, 8'h20, 3'd5, 1'b0);
    addVec("mid_hold", 1'b1, 1'b1, 8'h20, 8'h20, 3'd5, 1'b0);
    addVec("mid_rst",  1'b0, 1'b1, 8'h20, 8'h00, 3'd0, 1'b0);
    addVec("post_g5",  1'b1, 1'b1, 8'h21, 8'h20, 3'd5, 1'b0);
    addVec("post_rel", 1'b1, 1'b1, 8'h01, 8'h00, 3'd5, 1'b0);
    addVec("post_g0",  1'b1, 1'b1, 8'h01, 8'h01, 3'd0, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end
    checkValue("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    // Lone requester held: count grant cycles up to the forced release, then the gap before regrant.
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'h80;
    held  = 0;
    seen  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (timeout) begin
        seen = 1'b1;
        break;
      end
      if (gnt_valid) held++;
    end
    checkValue("seq_timeout_seen", 32'(seen), 32'd1);
    checkValue("seq_hold_cycles", 32'(held), 32'(MAX_HOLD));
    checkValue("seq_gnt_at_timeout", 32'(gnt), 32'd0);
    zeros = 1;
    got   = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (gnt_valid) begin
        got = 1'b1;
        break;
      end
      zeros++;
    end
    checkValue("seq_regrant_seen", 32'(got), 32'd1);
    checkValue("seq_idle_cycles", 32'(zeros), 32'd2);
    checkValue("seq_regrant_id", 32'(gnt_id), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
